// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller. The pipeline side (master) presents the register
//                index and control fields of the IF/ID, ID/EX, EX/MEM and
//                MEM/WB registers plus the data-memory handshake. The
//                controller side (slave) returns stall/flush controls, the EX
//                forwarding selects, the sticky timeout flag and the
//                saturating hazard counters.
//  Ports       : id_rs1/id_rs2/id_uses_rs1/id_uses_rs2  ID source operands
//                ex_rs1/ex_rs2/ex_rd/ex_mem_read         ID/EX fields
//                ex_redirect                              EX taken branch/jump
//                mem_rd/mem_reg_write, wb_rd/wb_reg_write MEM and WB writers
//                dmem_req/dmem_ready                      data memory handshake
//                stall_*/flush_*                          pipeline register ctl
//                fwd_a_sel/fwd_b_sel                      EX operand muxes
//                mem_timeout_err, stall_cycles, flush_events
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic [4:0]       mem_rd;
    logic [4:0]       wb_rd;
    logic             mem_reg_write;
    logic             wb_reg_write;
    logic             dmem_req;
    logic             dmem_ready;

    logic             stall_pc;
    logic             stall_if_id;
    logic             stall_id_ex;
    logic             stall_ex_mem;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect,
        output mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        output dmem_req, dmem_ready,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        input  flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel,
        input  mem_timeout_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_redirect,
        input  mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        input  dmem_req, dmem_ready,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
        output flush_if_id, flush_id_ex, fwd_a_sel, fwd_b_sel,
        output mem_timeout_err, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller for a 5-stage RISC-V pipeline. Freezes the
//                pipe while data memory is waiting (with a timeout escape),
//                squashes IF/ID and ID/EX on EX redirects, inserts a single
//                bubble on load-use, selects EX operand forwarding and keeps
//                saturating stall/flush counters.
//  Ports       : clk  core clock
//                rst  synchronous reset, active-low
//                bus  hazard_ctrl_if.slave (pipeline fields in, controls out)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    hazard_ctrl_if.slave    bus
);

    localparam int                c_WAIT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LU_BUBBLE = 2'd1,
        ST_MEM_WAIT  = 2'd2
    } state_t;

    state_t              r_state_q,        w_state_d;
    logic [c_WAIT_W-1:0] r_wait_cnt_q,     w_wait_cnt_d;
    logic                r_release_q,      w_release_d;
    logic                r_err_q,          w_err_d;
    logic [CNT_W-1:0]    r_stall_cycles_q, w_stall_cycles_d;
    logic [CNT_W-1:0]    r_flush_events_q, w_flush_events_d;

    logic w_mem_wait;
    logic w_timeout;
    logic w_redirect;
    logic w_load_use;
    logic w_stall_pc;

    always_comb begin
        // r_release_q gives the one free cycle after a timeout, even when
        // the memory is still not ready.
        w_mem_wait = !r_release_q && !bus.dmem_ready &&
                     (bus.dmem_req || (r_state_q == ST_MEM_WAIT));
        // The cycle that would make the wait count reach MEM_TIMEOUT.
        w_timeout  = w_mem_wait && (r_wait_cnt_q == c_WAIT_LAST);
        // A redirect during a wait is frozen in EX and serviced on exit.
        w_redirect = !w_mem_wait && bus.ex_redirect;
        // Squashed ID instruction needs no bubble; LU_BUBBLE already holds one.
        w_load_use = !w_mem_wait && !bus.ex_redirect &&
                     (r_state_q != ST_LU_BUBBLE) &&
                     bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                     ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                      (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

        w_stall_pc       = w_mem_wait || w_load_use;
        bus.stall_pc     = w_stall_pc;
        bus.stall_if_id  = w_mem_wait || w_load_use;
        bus.stall_id_ex  = w_mem_wait;
        bus.stall_ex_mem = w_mem_wait;
        bus.flush_if_id  = w_redirect;
        bus.flush_id_ex  = w_redirect || w_load_use;

        // MEM result is younger than WB, so it wins; x0 is never forwarded.
        bus.fwd_a_sel = 2'b00;
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.ex_rs1))
            bus.fwd_a_sel = 2'b01;
        else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.ex_rs1))
            bus.fwd_a_sel = 2'b10;

        bus.fwd_b_sel = 2'b00;
        if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.ex_rs2))
            bus.fwd_b_sel = 2'b01;
        else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.ex_rs2))
            bus.fwd_b_sel = 2'b10;

        bus.mem_timeout_err = r_err_q;
        bus.stall_cycles    = r_stall_cycles_q;
        bus.flush_events    = r_flush_events_q;
    end

    always_comb begin
        w_state_d        = ST_RUN;
        w_wait_cnt_d     = '0;
        w_release_d      = 1'b0;
        w_err_d          = r_err_q;
        w_stall_cycles_d = r_stall_cycles_q;
        w_flush_events_d = r_flush_events_q;

        if (w_mem_wait) begin
            if (w_timeout) begin
                w_state_d   = ST_RUN;
                w_release_d = 1'b1;
                w_err_d     = 1'b1;
            end else begin
                w_state_d    = ST_MEM_WAIT;
                w_wait_cnt_d = r_wait_cnt_q + c_WAIT_W'(1);
            end
        end else if (w_load_use) begin
            w_state_d = ST_LU_BUBBLE;
        end

        if (w_stall_pc && (r_stall_cycles_q != '1))
            w_stall_cycles_d = r_stall_cycles_q + CNT_W'(1);
        if (w_redirect && (r_flush_events_q != '1))
            w_flush_events_d = r_flush_events_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q        <= ST_RUN;
            r_wait_cnt_q     <= '0;
            r_release_q      <= 1'b0;
            r_err_q          <= 1'b0;
            r_stall_cycles_q <= '0;
            r_flush_events_q <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_wait_cnt_q     <= w_wait_cnt_d;
            r_release_q      <= w_release_d;
            r_err_q          <= w_err_d;
            r_stall_cycles_q <= w_stall_cycles_d;
            r_flush_events_q <= w_flush_events_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl with
//                MEM_TIMEOUT=4 and CNT_W=4 so timeout and saturation are
//                reachable in a few cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(4)) bus ();

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex}
    wire [5:0] ctl = {bus.stall_pc, bus.stall_if_id, bus.stall_id_ex,
                      bus.stall_ex_mem, bus.flush_if_id, bus.flush_id_ex};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
        bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
        bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0; bus.ex_rd = 5'd0;
        bus.ex_mem_read = 1'b0; bus.ex_redirect = 1'b0;
        bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
        bus.mem_reg_write = 1'b0; bus.wb_reg_write = 1'b0;
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
    endtask

    task automatic load_use_inputs();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000); end
        checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_stall_cycles: got %0d expected 0", bus.stall_cycles); end
        checks++; if (bus.flush_events !== 4'd0) begin errors++; $display("FAIL reset_flush_events: got %0d expected 0", bus.flush_events); end
        checks++; if (bus.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.mem_timeout_err); end
        checks++; if ({bus.fwd_a_sel, bus.fwd_b_sel} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", {bus.fwd_a_sel, bus.fwd_b_sel}); end
        step();
    endtask

    task automatic test_load_use();
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1'b1;
        bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
        settle();
        checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctl, 6'b110001); end
        step();
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_bubble_no_stall: got %b expected %b", ctl, 6'b000000); end
        checks++; if (bus.stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_stall_cycles: got %0d expected 1", bus.stall_cycles); end
        idle();
        step();
    endtask

    task automatic test_no_hazard();
        idle();
        bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0;
        bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1;
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_x0: got %b expected %b", ctl, 6'b000000); end
        bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b0;
        bus.id_rs2 = 5'd6; bus.id_uses_rs2 = 1'b1;
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL lu_unused_rs1: got %b expected %b", ctl, 6'b000000); end
        step();
        checks++; if (bus.stall_cycles !== 4'd1) begin errors++; $display("FAIL nohz_stall_cycles: got %0d expected 1", bus.stall_cycles); end
        idle();
    endtask

    task automatic test_mem_wait_redirect();
        idle();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0; bus.ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL memwait_stall[%0d]: got %b expected %b", i, ctl, 6'b111100); end
            step();
        end
        bus.dmem_ready = 1'b1;
        settle();
        checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL memwait_exit_flush: got %b expected %b", ctl, 6'b000011); end
        step();
        checks++; if (bus.flush_events !== 4'd1) begin errors++; $display("FAIL memwait_flush_events: got %0d expected 1", bus.flush_events); end
        checks++; if (bus.stall_cycles !== 4'd4) begin errors++; $display("FAIL memwait_stall_cycles: got %0d expected 4", bus.stall_cycles); end
        idle();
        step();
    endtask

    task automatic test_timeout();
        idle();
        bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL timeout_stall[%0d]: got %b expected %b", i, ctl, 6'b111100); end
            checks++; if (bus.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_early[%0d]: got %b expected 0", i, bus.mem_timeout_err); end
            step();
        end
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL timeout_release: got %b expected %b", ctl, 6'b000000); end
        checks++; if (bus.mem_timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b expected 1", bus.mem_timeout_err); end
        step();
        settle();
        checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL timeout_reenter: got %b expected %b", ctl, 6'b111100); end
        step();
        bus.dmem_req = 1'b0; bus.dmem_ready = 1'b1;
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL timeout_exit: got %b expected %b", ctl, 6'b000000); end
        step();
        checks++; if (bus.mem_timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_sticky: got %b expected 1", bus.mem_timeout_err); end
        checks++; if (bus.stall_cycles !== 4'd9) begin errors++; $display("FAIL timeout_stall_cycles: got %0d expected 9", bus.stall_cycles); end
        idle();
    endtask

    task automatic test_redirect();
        idle();
        load_use_inputs();
        bus.ex_rd = 5'd9; bus.id_rs1 = 5'd9;
        bus.ex_redirect = 1'b1;
        settle();
        checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL redirect_suppress_lu: got %b expected %b", ctl, 6'b000011); end
        step();
        bus.ex_mem_read = 1'b0;
        settle();
        checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL redirect_back_to_back: got %b expected %b", ctl, 6'b000011); end
        step();
        checks++; if (bus.flush_events !== 4'd3) begin errors++; $display("FAIL redirect_flush_events: got %0d expected 3", bus.flush_events); end
        checks++; if (bus.stall_cycles !== 4'd9) begin errors++; $display("FAIL redirect_stall_cycles: got %0d expected 9", bus.stall_cycles); end
        idle();
    endtask

    task automatic test_forwarding();
        idle();
        bus.mem_rd = 5'd7; bus.wb_rd = 5'd7; bus.ex_rs1 = 5'd7;
        bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
        settle();
        checks++; if (bus.fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_a_mem_prio: got %b expected 01", bus.fwd_a_sel); end
        bus.mem_reg_write = 1'b0;
        settle();
        checks++; if (bus.fwd_a_sel !== 2'b10) begin errors++; $display("FAIL fwd_a_wb: got %b expected 10", bus.fwd_a_sel); end
        bus.wb_reg_write = 1'b0;
        settle();
        checks++; if (bus.fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fwd_a_none: got %b expected 00", bus.fwd_a_sel); end
        bus.ex_rs2 = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
        bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
        settle();
        checks++; if (bus.fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_b_x0: got %b expected 00", bus.fwd_b_sel); end
        bus.ex_rs2 = 5'd7; bus.wb_rd = 5'd7; bus.mem_rd = 5'd3;
        settle();
        checks++; if (bus.fwd_b_sel !== 2'b10) begin errors++; $display("FAIL fwd_b_wb: got %b expected 10", bus.fwd_b_sel); end
        idle();
    endtask

    task automatic test_saturate();
        idle();
        // 19 = 2^CNT_W + 3 load-use stalls, each followed by its bubble cycle.
        for (int i = 0; i < 19; i++) begin
            load_use_inputs();
            step();
            step();
        end
        checks++; if (bus.stall_cycles !== 4'hF) begin errors++; $display("FAIL saturate_stall_cycles: got %0d expected 15", bus.stall_cycles); end
        checks++; if (bus.flush_events !== 4'd3) begin errors++; $display("FAIL saturate_flush_events: got %0d expected 3", bus.flush_events); end
        idle();
    endtask

    task automatic test_reset_mid_bubble();
        idle();
        load_use_inputs();
        step();
        settle();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL midrst_in_bubble: got %b expected %b", ctl, 6'b000000); end
        rst = 1'b0;
        step();
        rst = 1'b1;
        settle();
        checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL midrst_back_in_run: got %b expected %b", ctl, 6'b110001); end
        checks++; if (bus.stall_cycles !== 4'd0) begin errors++; $display("FAIL midrst_stall_cycles: got %0d expected 0", bus.stall_cycles); end
        checks++; if (bus.flush_events !== 4'd0) begin errors++; $display("FAIL midrst_flush_events: got %0d expected 0", bus.flush_events); end
        checks++; if (bus.mem_timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", bus.mem_timeout_err); end
        idle();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_wait_redirect();
        test_timeout();
        test_redirect();
        test_forwarding();
        test_saturate();
        test_reset_mid_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
